// File: rtl/pipeline_queue_pkg.sv
// pipeline_queue_pkg: packed decode-to-ROB payload layout shared by decode, queue and dispatch.
package pipeline_queue_pkg;
  localparam int PQ_OPC_W = 7;
  localparam int PQ_REG_W = 5;
  localparam int PQ_IMM_W = 10;
  typedef struct packed {
    logic [PQ_IMM_W-1:0] imm;
    logic [PQ_REG_W-1:0] rs2;
    logic [PQ_REG_W-1:0] rs1;
    logic [PQ_REG_W-1:0] rd;
    logic [PQ_OPC_W-1:0] opc;
  } pq_payload_t;
  localparam int PQ_OPC_LSB = 0;
  localparam int PQ_RD_LSB = PQ_OPC_LSB + PQ_OPC_W;
  localparam int PQ_RS1_LSB = PQ_RD_LSB + PQ_REG_W;
  localparam int PQ_RS2_LSB = PQ_RS1_LSB + PQ_REG_W;
  localparam int PQ_IMM_LSB = PQ_RS2_LSB + PQ_REG_W;
  localparam int PQ_PAYLOAD_W = $bits(pq_payload_t);
endpackage

// File: rtl/pipeline_queue_ram.sv
// pipeline_queue_ram: DEPTHxWIDTH register array, synchronous write, asynchronous read.
module pipeline_queue_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pipeline_queue.sv
// pipeline_queue: elastic DEPTH-entry valid/ready FIFO stage with almost_full stall and one-cycle flush.
module pipeline_queue
  import pipeline_queue_pkg::*;
#(
  parameter int WIDTH = PQ_PAYLOAD_W,
  parameter int DEPTH = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop, we;
  logic [WIDTH-1:0] rdata;
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign almost_full = count_q >= CW'(AFULL_LEVEL);
  assign count = count_q;
  assign out_data = out_valid ? rdata : '0;
  always_comb begin
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    we = push & ~flush & ~rst;
    head_d = flush ? '0 : head_q + AW'(pop);
    tail_d = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  pipeline_queue_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we), .waddr(tail_q), .wdata(in_data), .raddr(head_q), .rdata(rdata)
  );
endmodule

// File: tb/tb_pipeline_queue.sv
// tb_pipeline_queue: directed and random traffic against a queue-based reference model.
module tb_pipeline_queue;
  localparam int DEPTH = 4;
  localparam int AFL = 3;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, almost_full;
  logic [31:0] out_data;
  logic [2:0] count;
  int err = 0, chk = 0;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  pipeline_queue #(.WIDTH(32), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full)
  );
  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl, output logic acc);
    logic ps, pp;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    ps = iv && q.size() < DEPTH;
    pp = ordy && q.size() > 0;
    acc = ps;
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(id);
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0; flush = 0;
  endtask
  task automatic test_reset;
    logic a;
    rst = 1;
    repeat (2) drive(1, 32'h77, 0, 0, a);
    rst = 0;
    chk++; if (count !== 0) begin err++; $display("FAIL reset_count got=%0d exp=0", count); end
    chk++; if (out_valid !== 0) begin err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    chk++; if (out_data !== 0) begin err++; $display("FAIL reset_data got=%h exp=0", out_data); end
    chk++; if (in_ready !== 1) begin err++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    chk++; if (almost_full !== 0) begin err++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    drive(1, 32'h1, 0, 0, a);
    drive(1, 32'h2, 0, 0, a);
    rst = 1; drive(1, 32'h3, 1, 0, a); rst = 0;
    chk++; if (count !== 0 || out_valid !== 0) begin err++; $display("FAIL midreset got count=%0d valid=%b exp 0/0", count, out_valid); end
  endtask
  task automatic test_fill;
    logic a;
    logic [31:0] v [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1, v[i], 0, 0, a);
      chk++; if (count !== 3'(i + 1)) begin err++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
      chk++; if (almost_full !== (i + 1 >= AFL)) begin err++; $display("FAIL fill_afull got=%b at count %0d", almost_full, i + 1); end
      chk++; if (in_ready !== (i + 1 < DEPTH)) begin err++; $display("FAIL fill_ready got=%b at count %0d", in_ready, i + 1); end
    end
    drive(1, 32'h55, 0, 0, a);
    chk++; if (count !== 4 || out_data !== 32'h11) begin err++; $display("FAIL fill_hold got count=%0d data=%h exp 4/11", count, out_data); end
  endtask
  task automatic test_drain_wrap;
    logic a;
    logic [31:0] e [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    for (int i = 0; i < 2; i++) begin
      chk++; if (out_data !== e[i]) begin err++; $display("FAIL wrap_pop%0d got=%h exp=%h", i, out_data, e[i]); end
      drive(0, 0, 1, 0, a);
    end
    drive(1, 32'h55, 0, 0, a);
    drive(1, 32'h66, 0, 0, a);
    chk++; if (count !== 4) begin err++; $display("FAIL wrap_refill got=%0d exp=4", count); end
    for (int i = 2; i < 6; i++) begin
      chk++; if (out_valid !== 1 || out_data !== e[i]) begin err++; $display("FAIL wrap_pop%0d got=%h v=%b exp=%h", i, out_data, out_valid, e[i]); end
      drive(0, 0, 1, 0, a);
    end
    chk++; if (count !== 0 || out_valid !== 0 || out_data !== 0) begin err++; $display("FAIL wrap_empty got count=%0d data=%h", count, out_data); end
    drive(0, 0, 1, 0, a);
    chk++; if (count !== 0) begin err++; $display("FAIL underflow got=%0d exp=0", count); end
  endtask
  task automatic test_back_to_back;
    logic a;
    drive(1, 32'h100, 0, 0, a);
    drive(1, 32'h101, 0, 0, a);
    for (int i = 0; i < 10; i++) begin
      chk++; if (out_data !== 32'h100 + i) begin err++; $display("FAIL b2b_data%0d got=%h exp=%h", i, out_data, 32'h100 + i); end
      drive(1, 32'h102 + i, 1, 0, a);
      chk++; if (count !== 2) begin err++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count); end
    end
    drive(0, 0, 1, 0, a);
    drive(0, 0, 1, 0, a);
  endtask
  task automatic test_flush;
    logic a;
    for (int i = 0; i < 3; i++) drive(1, 32'hA0 + i, 0, 0, a);
    drive(1, 32'hDEAD, 1, 1, a);
    chk++; if (count !== 0) begin err++; $display("FAIL flush_count got=%0d exp=0", count); end
    chk++; if (out_valid !== 0 || out_data !== 0) begin err++; $display("FAIL flush_out got v=%b d=%h exp 0/0", out_valid, out_data); end
    chk++; if (in_ready !== 1 || almost_full !== 0) begin err++; $display("FAIL flush_flags got r=%b af=%b exp 1/0", in_ready, almost_full); end
    drive(1, 32'hB0, 0, 0, a);
    chk++; if (count !== 1 || out_data !== 32'hB0) begin err++; $display("FAIL flush_after got count=%0d data=%h exp 1/b0", count, out_data); end
    drive(0, 0, 1, 0, a);
  endtask
  task automatic test_random;
    logic hv = 0, a;
    logic [31:0] hd = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!hv && $urandom_range(3) != 0) begin hv = 1; hd = $urandom; end
      drive(hv, hd, $urandom_range(2) != 0, $urandom_range(96) == 0, a);
      if (a) hv = 0;
      chk++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH) ||
          almost_full !== (q.size() >= AFL) || out_data !== (q.size() != 0 ? q[0] : 32'h0)) begin
        err++;
        $display("FAIL rand_cyc%0d got count=%0d v=%b r=%b af=%b d=%h exp count=%0d d=%h",
                 c, count, out_valid, in_ready, almost_full, out_data, q.size(), q.size() != 0 ? q[0] : 32'h0);
      end
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_fill;
    test_drain_wrap;
    test_back_to_back;
    test_flush;
    test_random;
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
